// File: rtl/uart_pkt_rx.sv
// uart_pkt_rx: frames SYNC/LEN/payload/CSUM packets from a UART byte stream.
// Define UART_PKT_TIMEOUT_EN to enable the inter-byte idle timeout.
module uart_pkt_rx #(
    parameter int unsigned MAX_LEN        = 16,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_data,
    input  logic       i_vld,
    output logic [7:0] o_data,
    output logic       o_vld,
    input  logic       i_rdy,
    output logic       o_last,
    output logic       o_err,
    output logic [1:0] o_err_code
);

    localparam int unsigned IW = $clog2(MAX_LEN + 1);
    localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [2:0] {
        S_SYNC,
        S_LEN,
        S_PAY,
        S_CSUM,
        S_DRAIN
    } state_t;

    state_t        state_q;
    logic [IW-1:0] len_q;
    logic [IW-1:0] wr_q;
    logic [IW-1:0] rd_q;
    logic [7:0]    csum_q;
    logic [7:0]    data_q;
    logic          vld_q;
    logic          last_q;
    logic          err_q;
    logic [1:0]    code_q;
    logic [7:0]    mem_q [MAX_LEN];

    logic [IW-1:0] wr_d;
    logic [IW-1:0] rd_d;
    logic [IW-1:0] last_idx;
    logic          len_ok;
    logic          xfer;

    assign wr_d     = wr_q + IW'(1);
    assign rd_d     = rd_q + IW'(1);
    assign last_idx = len_q - IW'(1);
    assign len_ok   = (i_data != 8'd0) && (32'(i_data) <= MAX_LEN);
    assign xfer     = vld_q && i_rdy;

    assign o_data     = data_q;
    assign o_vld      = vld_q;
    assign o_last     = last_q;
    assign o_err      = err_q;
    assign o_err_code = code_q;

`ifdef UART_PKT_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q;
    logic          tmo_hit;
    logic          busy;
    assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    assign busy    = (state_q == S_LEN) || (state_q == S_PAY) ||
                     (state_q == S_CSUM);
`else
    logic unused_tmo;
    assign unused_tmo = |TIMEOUT_CYCLES;
`endif

    // Payload buffer; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (state_q == S_PAY && i_vld) begin
            mem_q[wr_q[AW-1:0]] <= i_data;
        end
    end

    // Packet parser FSM with registered stream and error outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_SYNC;
            len_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            csum_q  <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'd0;
`ifdef UART_PKT_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                S_SYNC: begin
                    if (i_vld && i_data == SYNC_BYTE) begin
                        state_q <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (i_vld) begin
                        if (len_ok) begin
                            len_q   <= IW'(i_data);
                            csum_q  <= i_data;
                            wr_q    <= '0;
                            state_q <= S_PAY;
                        end else begin
                            err_q   <= 1'b1;
                            code_q  <= 2'd0;
                            state_q <= S_SYNC;
                        end
                    end
                end
                S_PAY: begin
                    if (i_vld) begin
                        csum_q <= csum_q ^ i_data;
                        wr_q   <= wr_d;
                        if (wr_d == len_q) begin
                            state_q <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (i_vld) begin
                        if (i_data == csum_q) begin
                            state_q <= S_DRAIN;
                            rd_q    <= '0;
                            data_q  <= mem_q[0];
                            vld_q   <= 1'b1;
                            last_q  <= (len_q == IW'(1));
                        end else begin
                            err_q   <= 1'b1;
                            code_q  <= 2'd1;
                            state_q <= S_SYNC;
                        end
                    end
                end
                S_DRAIN: begin
                    if (i_vld) begin
                        err_q  <= 1'b1;
                        code_q <= 2'd2;
                    end
                    if (xfer) begin
                        if (last_q) begin
                            state_q <= S_SYNC;
                            vld_q   <= 1'b0;
                            last_q  <= 1'b0;
                            rd_q    <= '0;
                        end else begin
                            rd_q   <= rd_d;
                            data_q <= mem_q[rd_d[AW-1:0]];
                            last_q <= (rd_d == last_idx);
                        end
                    end
                end
                default: state_q <= S_SYNC;
            endcase
`ifdef UART_PKT_TIMEOUT_EN
            if (busy && !i_vld) begin
                if (tmo_hit) begin
                    tmo_q   <= '0;
                    err_q   <= 1'b1;
                    code_q  <= 2'd3;
                    state_q <= S_SYNC;
                end else begin
                    tmo_q <= tmo_q + TW'(1);
                end
            end else begin
                tmo_q <= '0;
            end
`endif
        end
    end

endmodule
